spi_block_ctrl: RTL and testbench

Sequences the byte-wide SPI master to move one full 128-bit AES block (16 bytes) to and from the SPI slave in a single request. Sits between the AES core and the SPI master. Latches the plaintext/ciphertext block, issues one byte transfer at a time with a programmable inter-byte gap, and reassembles the received bytes into a 128-bit result. A watchdog aborts the block if a byte transfer never completes.

---
 rtl/spi_ctrl_pkg.sv | 26 ++
 rtl/spi_byte_timer.sv | 29 ++
 rtl/spi_block_ctrl.sv | 160 ++++++++++++++++
 tb/tb_spi_block_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI block controller and the byte-wide SPI master:
// state encoding, AES block width and index-width helper.
package spi_ctrl_pkg;

  localparam int AES_BLOCK_W = 128;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_ISSUE = S_ISSUE,
    ST_WAIT  = S_WAIT,
    ST_GAP   = S_GAP,
    ST_DONE  = S_DONE
  } state_e;

  // A single-byte block still needs a one-bit index register.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_byte_timer.sv
// Loadable down-counter that stops at zero; zero_o flags the expired count.
module spi_byte_timer
  import spi_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/spi_block_ctrl.sv
// Moves one block through the byte-wide SPI master, MSB byte first, with a
// programmable inter-byte gap and a per-byte completion watchdog.
module spi_block_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int NUM_BYTES      = AES_BLOCK_W / 8,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     blk_start,
  input  logic [8*NUM_BYTES-1:0]   tx_block,
  output logic [8*NUM_BYTES-1:0]   rx_block,
  output logic                     blk_busy,
  output logic                     blk_done,
  output logic                     blk_err,
  output logic                     byte_start,
  output logic [7:0]               byte_data,
  input  logic                     byte_busy,
  input  logic                     byte_done,
  input  logic [7:0]               byte_rx
);

  localparam int BLK_W = 8 * NUM_BYTES;
  localparam int IW    = idx_w(NUM_BYTES);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1) + 1;

  // Timers are loaded one cycle before they start counting, hence the -1/-2.
  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYCLES - 2);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IW-1:0]    LAST_IDX = IW'(NUM_BYTES - 1);

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [BLK_W-1:0] shift_q, shift_d;
  logic [BLK_W-1:0] rx_q, rx_d;
  logic [7:0]       byte_data_q, byte_data_d;
  logic             blk_busy_q, blk_busy_d;
  logic             blk_done_q, blk_done_d;
  logic             blk_err_q, blk_err_d;
  logic             start_d;
  logic             to_load, to_zero, gap_load, gap_zero;
  int               slot;

  spi_byte_timer #(.W(TO_W)) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .load_i    (to_load),
    .load_val_i(TO_LOAD),
    .dec_i     (state_q == ST_WAIT),
    .zero_o    (to_zero)
  );

  spi_byte_timer #(.W(GAP_W)) u_gap (
    .clk       (clk),
    .reset     (reset),
    .load_i    (gap_load),
    .load_val_i(GAP_LOAD),
    .dec_i     (state_q == ST_GAP),
    .zero_o    (gap_zero)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    rx_d        = rx_q;
    byte_data_d = byte_data_q;
    blk_done_d  = 1'b0;
    blk_err_d   = 1'b0;
    start_d     = 1'b0;
    to_load     = 1'b0;
    gap_load    = 1'b0;
    slot        = BLK_W - 8 - 8 * int'(idx_q);
    case (state_q)
      ST_IDLE: begin
        if (blk_start) begin
          state_d     = ST_ISSUE;
          idx_d       = '0;
          rx_d        = '0;
          byte_data_d = tx_block[BLK_W-1 -: 8];
          shift_d     = tx_block << 8;
        end
      end
      ST_ISSUE: begin
        if (!byte_busy) begin
          start_d = 1'b1;
          to_load = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A completing byte beats a watchdog expiring in the same cycle.
        if (byte_done) begin
          rx_d[slot +: 8] = byte_rx;
          if (idx_q == LAST_IDX) begin
            state_d    = ST_DONE;
            blk_done_d = 1'b1;
          end else if (GAP_CYCLES == 0) begin
            state_d     = ST_ISSUE;
            idx_d       = idx_q + IW'(1);
            byte_data_d = shift_q[BLK_W-1 -: 8];
            shift_d     = shift_q << 8;
          end else begin
            state_d  = ST_GAP;
            gap_load = 1'b1;
          end
        end else if (to_zero) begin
          state_d   = ST_IDLE;
          blk_err_d = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_zero) begin
          state_d     = ST_ISSUE;
          idx_d       = idx_q + IW'(1);
          byte_data_d = shift_q[BLK_W-1 -: 8];
          shift_d     = shift_q << 8;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    blk_busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rx_q        <= '0;
      byte_data_q <= '0;
      blk_busy_q  <= 1'b0;
      blk_done_q  <= 1'b0;
      blk_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_q        <= rx_d;
      byte_data_q <= byte_data_d;
      blk_busy_q  <= blk_busy_d;
      blk_done_q  <= blk_done_d;
      blk_err_q   <= blk_err_d;
    end
  end

  always_ff @(posedge clk) begin
    idx_q   <= idx_d;
    shift_q <= shift_d;
  end

  // Start follows byte_busy in the same cycle so a stalled ISSUE fires immediately on release.
  assign byte_start = start_d && !reset;
  assign byte_data  = byte_data_q;
  assign rx_block   = rx_q;
  assign blk_busy   = blk_busy_q;
  assign blk_done   = blk_done_q;
  assign blk_err    = blk_err_q;

endmodule

// File: tb/tb_spi_block_ctrl.sv
// Scoreboard bench for spi_block_ctrl with behavioural SPI-master models.
module tb_spi_block_ctrl;

  localparam int BW  = 128;
  localparam int LAT = 4;

  typedef struct {
    logic          err;
    logic [BW-1:0] rx;
  } exp_t;

  logic          clk;
  logic          reset, blk_start;
  logic [BW-1:0] tx_block, rx_block;
  logic          blk_busy, blk_done, blk_err, byte_start;
  logic [7:0]    byte_data, byte_rx;
  logic          byte_busy, byte_done, slv_busy, force_busy;

  logic          blk_start0;
  logic [BW-1:0] tx0, rx0;
  logic          busy0, done0, err0, bstart0, bbusy0, bdone0;
  logic [7:0]    bdata0, brx0;

  int checks = 0, failures = 0, cyc = 0;
  int nstart = 0, n0 = 0, mode = 0;
  int hang_abs = -1, slow_abs = -1, slow_lat = LAT;
  int st[256];
  int st0[32];
  exp_t q[$];
  exp_t q0[$];

  assign byte_busy = slv_busy | force_busy;

  spi_block_ctrl #(.NUM_BYTES(16), .GAP_CYCLES(2), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .blk_start(blk_start), .tx_block(tx_block),
    .rx_block(rx_block), .blk_busy(blk_busy), .blk_done(blk_done), .blk_err(blk_err),
    .byte_start(byte_start), .byte_data(byte_data), .byte_busy(byte_busy),
    .byte_done(byte_done), .byte_rx(byte_rx)
  );

  spi_block_ctrl #(.NUM_BYTES(16), .GAP_CYCLES(0), .TIMEOUT_CYCLES(64)) dut0 (
    .clk(clk), .reset(reset), .blk_start(blk_start0), .tx_block(tx0),
    .rx_block(rx0), .blk_busy(busy0), .blk_done(done0), .blk_err(err0),
    .byte_start(bstart0), .byte_data(bdata0), .byte_busy(bbusy0),
    .byte_done(bdone0), .byte_rx(brx0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic expire(input string nm);
    checks++;
    failures++;
    $display("FAIL %s wait budget expired", nm);
  endtask

  task automatic push(input logic err, input logic [BW-1:0] rx);
    exp_t e;
    e.err = err;
    e.rx  = rx;
    q.push_back(e);
  endtask

  task automatic start_blk(input logic [BW-1:0] tx, output int t_acc);
    @(posedge clk); #1;
    blk_start = 1'b1;
    tx_block  = tx;
    t_acc     = cyc;
    @(posedge clk); #1;
    blk_start = 1'b0;
    tx_block  = ~tx;
  endtask

  task automatic wait_end(input string nm, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (blk_done || blk_err) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) expire(nm);
  endtask

  task automatic wait_starts(input string nm, input int target, input int budget);
    int ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (nstart >= target) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) expire(nm);
  endtask

  // Master model: busy for LAT-1 cycles, then done with loopback or inverted data.
  initial begin : slave
    logic [7:0] d;
    int me, lat;
    slv_busy = 1'b0; byte_done = 1'b0; byte_rx = 8'h00;
    forever begin
      @(negedge clk);
      if (byte_start) begin
        d = byte_data;
        me = nstart;
        st[me] = cyc;
        nstart++;
        if (me != hang_abs) begin
          lat = (me == slow_abs) ? slow_lat : LAT;
          @(posedge clk); #1;
          slv_busy = 1'b1;
          for (int i = 1; i < lat; i++) begin
            @(posedge clk); #1;
          end
          slv_busy  = 1'b0;
          byte_done = 1'b1;
          byte_rx   = (mode == 1) ? ~d : d;
          @(posedge clk); #1;
          byte_done = 1'b0;
        end
      end
    end
  end

  initial begin : slave0
    logic [7:0] d;
    bbusy0 = 1'b0; bdone0 = 1'b0; brx0 = 8'h00;
    forever begin
      @(negedge clk);
      if (bstart0) begin
        d = bdata0;
        st0[n0] = cyc;
        n0++;
        @(posedge clk); #1;
        bbusy0 = 1'b1;
        for (int i = 1; i < LAT; i++) begin
          @(posedge clk); #1;
        end
        bbusy0 = 1'b0;
        bdone0 = 1'b1;
        brx0   = d;
        @(posedge clk); #1;
        bdone0 = 1'b0;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (blk_done || blk_err) begin
        if (q.size() == 0) begin
          chk("unexpected_blk_out", BW'({blk_done, blk_err}), BW'(0));
        end else begin
          e = q.pop_front();
          chk("blk_err_kind", BW'(blk_err), BW'(e.err));
          chk("blk_done_kind", BW'(blk_done), BW'(!e.err));
          chk("rx_block", rx_block, e.rx);
        end
      end
      if (done0 || err0) begin
        if (q0.size() == 0) begin
          chk("unexpected_blk_out0", BW'({done0, err0}), BW'(0));
        end else begin
          e = q0.pop_front();
          chk("blk_done0_kind", BW'(done0), BW'(!e.err));
          chk("rx_block0", rx0, e.rx);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base, t, t_acc, rel, ok;
    exp_t e;
    reset = 1'b1; blk_start = 1'b0; tx_block = '0; force_busy = 1'b0;
    blk_start0 = 1'b0; tx0 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rx_block", rx_block, '0);
    chk("rst_byte_data", BW'(byte_data), BW'(0));
    chk("rst_byte_start", BW'(byte_start), BW'(0));
    chk("rst_blk_busy", BW'(blk_busy), BW'(0));
    chk("rst_blk_done", BW'(blk_done), BW'(0));
    chk("rst_blk_err", BW'(blk_err), BW'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    // Zero-gap instance: loopback, back-to-back bytes
    e.err = 1'b0;
    e.rx  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    q0.push_back(e);
    @(posedge clk); #1;
    blk_start0 = 1'b1;
    tx0 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    @(posedge clk); #1;
    blk_start0 = 1'b0;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done0) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) expire("gap0_block");
    chk("gap0_starts", BW'(n0), BW'(16));
    chk("gap0_spacing_first", BW'(st0[1] - st0[0]), BW'(5));
    chk("gap0_spacing_last", BW'(st0[15] - st0[14]), BW'(5));

    // Loopback block
    mode = 0;
    base = nstart;
    push(1'b0, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    start_blk(128'h00112233_44556677_8899AABB_CCDDEEFF, t_acc);
    wait_end("loopback_block", 400, t);
    chk("loopback_starts", BW'(nstart - base), BW'(16));
    chk("first_start_latency", BW'(st[base] - t_acc), BW'(1));
    chk("done_latency", BW'(t - st[base+15]), BW'(LAT + 1));
    @(negedge clk);
    chk("busy_low_after_done", BW'(blk_busy), BW'(0));
    repeat (3) @(posedge clk);

    // Inverting slave, gap of 2
    mode = 1;
    base = nstart;
    push(1'b0, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF);
    start_blk('0, t_acc);
    wait_end("invert_block", 400, t);
    chk("gap2_spacing_first", BW'(st[base+1] - st[base]), BW'(7));
    chk("gap2_spacing_last", BW'(st[base+15] - st[base+14]), BW'(7));
    repeat (3) @(posedge clk);

    // Watchdog abort on byte 3
    mode = 0;
    base = nstart;
    hang_abs = base + 3;
    push(1'b1, 128'h00112200_00000000_00000000_00000000);
    start_blk(128'h00112233_44556677_8899AABB_CCDDEEFF, t_acc);
    wait_end("timeout_block", 400, t);
    chk("timeout_latency", BW'(t - st[base+3]), BW'(64));
    chk("timeout_starts", BW'(nstart - base), BW'(4));
    @(negedge clk);
    chk("busy_low_after_err", BW'(blk_busy), BW'(0));
    hang_abs = -1;
    repeat (5) @(posedge clk);

    // blk_start during byte 5 ignored; restart right after DONE accepted
    base = nstart;
    push(1'b0, 128'h01234567_89ABCDEF_FEDCBA98_76543210);
    start_blk(128'h01234567_89ABCDEF_FEDCBA98_76543210, t_acc);
    wait_starts("reach_byte5", base + 6, 200);
    @(posedge clk); #1;
    blk_start = 1'b1;
    tx_block  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    @(posedge clk); #1;
    blk_start = 1'b0;
    wait_end("ignore_start_block", 400, t);
    chk("ignore_start_starts", BW'(nstart - base), BW'(16));
    mode = 1;
    base = nstart;
    push(1'b0, 128'h5A5A5A5A_A5A5A5A5_3C3C3C3C_C3C3C3C3);
    start_blk(128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C, t_acc);
    chk("b2b_accept_cycle", BW'(t_acc - t), BW'(1));
    wait_end("b2b_block", 400, t);
    chk("b2b_first_start", BW'(st[base] - t_acc), BW'(1));
    repeat (3) @(posedge clk);

    // byte_busy stall at ISSUE, then byte_done coinciding with watchdog expiry
    mode = 1;
    base = nstart;
    slow_abs = base + 2;
    slow_lat = 63;
    force_busy = 1'b1;
    push(1'b0, 128'h01234567_89ABCDEF_F0E1D2C3_B4A59687);
    start_blk(128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978, t_acc);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_no_start", BW'(byte_start), BW'(0));
    end
    @(posedge clk); #1;
    force_busy = 1'b0;
    rel = cyc;
    @(negedge clk);
    chk("stall_release_start", BW'(byte_start), BW'(1));
    wait_end("stall_block", 600, t);
    chk("stall_start_cycle", BW'(st[base] - rel), BW'(0));
    chk("stall_starts", BW'(nstart - base), BW'(16));
    chk("coincide_next_start", BW'(st[base+3] - st[base+2]), BW'(66));
    slow_abs = -1;
    slow_lat = LAT;
    mode = 0;
    repeat (3) @(posedge clk);

    // Reset during byte 8 WAIT, then a fresh block
    base = nstart;
    start_blk(128'h00112233_44556677_8899AABB_CCDDEEFF, t_acc);
    wait_starts("reach_byte8", base + 9, 200);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_rx_block", rx_block, '0);
    chk("midrst_byte_data", BW'(byte_data), BW'(0));
    chk("midrst_byte_start", BW'(byte_start), BW'(0));
    chk("midrst_blk_busy", BW'(blk_busy), BW'(0));
    chk("midrst_blk_done", BW'(blk_done), BW'(0));
    chk("midrst_blk_err", BW'(blk_err), BW'(0));
    repeat (8) @(posedge clk);
    base = nstart;
    push(1'b0, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF);
    start_blk(128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, t_acc);
    wait_end("post_reset_block", 400, t);
    chk("post_reset_starts", BW'(nstart - base), BW'(16));

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", BW'(q.size()), BW'(0));
    chk("scoreboard0_drained", BW'(q0.size()), BW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
